karatsuba32_seq_ctrl: RTL and testbench

Sequential scheduler for a 32x32 Karatsuba multiply that time-shares one external 18x18 unsigned multiplier across the three partial products: AH*BH, AL*BL and (AH+AL)*(BH+BL). It accepts operands over a valid/ready handshake, steps the shared multiplier through the three products, recombines them and presents a registered 64-bit product. It sits between the operand source and the shared multiplier. A per-operation flag tags the AL*BL product as approximate for the approx-capable multiplier.

---
 rtl/karatsuba32_seq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_karatsuba32_seq_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/karatsuba32_seq_ctrl.sv
// -----------------------------------------------------------------------------
// karatsuba32_seq_ctrl
//
// Sequential scheduler for an N x N Karatsuba multiply. One external MW x MW
// unsigned multiplier is time-shared across the three partial products
// AH*BH (M1), AL*BL (M2) and (AH+AL)*(BH+BL) (M3). The products are then
// recombined into a registered 2N-bit result.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   in_valid/ready  operand handshake (A, B, approx_en sampled on accept)
//   mul_x, mul_y    shared multiplier operands (zero when mul_en=0)
//   mul_en          shared multiplier operands valid this cycle
//   mul_approx      approximate-mode select, only during the AL*BL cycle
//   mul_p           shared multiplier product, combinational from mul_x/mul_y
//   out_valid/ready result handshake
//   P               registered 2N-bit product
//   busy            operation in flight
// -----------------------------------------------------------------------------
module karatsuba32_seq_ctrl #(
    parameter int N  = 32,
    parameter int K  = N / 2,
    parameter int MW = K + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      A,
    input  logic [N-1:0]      B,
    input  logic              approx_en,
    output logic [MW-1:0]     mul_x,
    output logic [MW-1:0]     mul_y,
    output logic              mul_en,
    output logic              mul_approx,
    input  logic [2*MW-1:0]   mul_p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*N-1:0]    P,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HH,
        S_LL,
        S_MID,
        S_SUM,
        S_OUT
    } state_t;

    state_t state, state_next;

    logic [N-1:0]    a_r, b_r;
    logic            approx_r;
    logic [2*MW-1:0] m1, m2, m3;
    logic [2*N-1:0]  p_r;
    logic            out_valid_r;

    // Operand halves and the K+1-bit middle sums.
    logic [K-1:0] ah, al, bh, bl;
    logic [K:0]   sum_a, sum_b;

    assign ah    = a_r[N-1:K];
    assign al    = a_r[K-1:0];
    assign bh    = b_r[N-1:K];
    assign bl    = b_r[K-1:0];
    assign sum_a = {1'b0, ah} + {1'b0, al};
    assign sum_b = {1'b0, bh} + {1'b0, bl};

    // Recombination. The middle term is an absolute difference: an approximate
    // M2 can push M1+M2 above M3. The final sum only uses +, - and left shifts,
    // so computing it modulo 2^(2N) equals truncating a wider result.
    logic [2*MW:0]  s12;
    logic [2*MW:0]  m3_x;
    logic [2*MW:0]  mid;
    logic [2*N-1:0] p_sum;

    always_comb begin
        s12   = {1'b0, m1} + {1'b0, m2};
        m3_x  = {1'b0, m3};
        mid   = (s12 > m3_x) ? (s12 - m3_x) : (m3_x - s12);
        p_sum = ((2*N)'(m1) << N) + ((2*N)'(mid) << K) + (2*N)'(m2);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r         <= '0;
            b_r         <= '0;
            approx_r    <= 1'b0;
            m1          <= '0;
            m2          <= '0;
            m3          <= '0;
            p_r         <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_r      <= A;
                        b_r      <= B;
                        approx_r <= approx_en;
                    end
                end
                S_HH:  m1 <= mul_p;
                S_LL:  m2 <= mul_p;
                S_MID: m3 <= mul_p;
                S_SUM: begin
                    p_r         <= p_sum;
                    out_valid_r <= 1'b1;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state and multiplier-port decode
    always_comb begin
        state_next = state;
        mul_x      = '0;
        mul_y      = '0;
        mul_en     = 1'b0;
        mul_approx = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_next = S_HH;
                end
            end
            S_HH: begin
                mul_x      = MW'(ah);
                mul_y      = MW'(bh);
                mul_en     = 1'b1;
                state_next = S_LL;
            end
            S_LL: begin
                mul_x      = MW'(al);
                mul_y      = MW'(bl);
                mul_en     = 1'b1;
                mul_approx = approx_r;
                state_next = S_MID;
            end
            S_MID: begin
                mul_x      = MW'(sum_a);
                mul_y      = MW'(sum_b);
                mul_en     = 1'b1;
                state_next = S_SUM;
            end
            S_SUM: begin
                state_next = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = out_valid_r;
    assign P         = p_r;

endmodule

// File: tb/tb_karatsuba32_seq_ctrl.sv
module tb_karatsuba32_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A, B;
    logic        approx_en;
    logic [17:0] mul_x, mul_y;
    logic        mul_en;
    logic        mul_approx;
    logic [35:0] mul_p;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] P;
    logic        busy;

    int vec   = 0;
    int fails = 0;

    logic [63:0] sb_q[$];
    logic [36:0] mul_log[$];
    int          mul_cnt   = 0;
    int          idle_viol = 0;

    karatsuba32_seq_ctrl #(.N(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .approx_en  (approx_en),
        .mul_x      (mul_x),
        .mul_y      (mul_y),
        .mul_en     (mul_en),
        .mul_approx (mul_approx),
        .mul_p      (mul_p),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .P          (P),
        .busy       (busy)
    );

    // Shared multiplier stub: exact product, plus 3 in approximate mode.
    always_comb begin
        mul_p = ({18'b0, mul_x} * {18'b0, mul_y}) + (mul_approx ? 36'd3 : 36'd0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier-port monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (mul_en === 1'b1) begin
            mul_cnt++;
            mul_log.push_back({mul_approx, mul_x, mul_y});
        end else if ((mul_x !== 18'd0) || (mul_y !== 18'd0) || (mul_approx !== 1'b0)) begin
            idle_viol++;
        end
    end

    // Reference for the approximate case: M2 is inflated by 3 and the middle
    // term is an absolute difference.
    function automatic logic [63:0] ref_approx(input logic [31:0] a, input logic [31:0] b);
        logic [65:0] m1, m2, m3, mid, s;
        m1  = 66'(a[31:16]) * 66'(b[31:16]);
        m2  = 66'(a[15:0]) * 66'(b[15:0]) + 66'd3;
        m3  = (66'(a[31:16]) + 66'(a[15:0])) * (66'(b[31:16]) + 66'(b[15:0]));
        mid = (m1 + m2 > m3) ? (m1 + m2 - m3) : (m3 - m1 - m2);
        s   = (m1 << 32) + (mid << 16) + m2;
        return s[63:0];
    endfunction

    // One full operation. hold>0 keeps out_ready low for that many cycles
    // after out_valid while in_valid and A/B toggle.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic ap, input int hold);
        logic [63:0] exp_p;
        int          cnt;
        int          pulses;
        exp_p = 64'd0;
        A = a; B = b; approx_en = ap; in_valid = 1'b1;
        out_ready = (hold == 0);
        vec++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL in_ready_idle: got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        sb_q.push_back(ap ? ref_approx(a, b) : ({32'b0, a} * {32'b0, b}));
        in_valid = 1'b0;
        A = $urandom; B = $urandom; approx_en = ~ap;
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        vec++;
        if (cnt != 4) begin
            fails++;
            $display("FAIL latency: got %0d cycles expected 4", cnt);
        end
        if (out_valid === 1'b1) begin
            exp_p = sb_q.pop_front();
            vec++;
            if (P !== exp_p) begin
                fails++;
                $display("FAIL product a=%h b=%h: got %h expected %h", a, b, P, exp_p);
            end
        end else begin
            void'(sb_q.pop_front());
            vec++;
            fails++;
            $display("FAIL out_valid_timeout: got 0 expected 1");
        end
        if (hold > 0) begin
            pulses = mul_cnt;
            repeat (hold) begin
                in_valid = 1'b1; A = $urandom; B = $urandom;
                @(posedge clk); #1;
                vec++;
                if ({out_valid, in_ready, P} !== {1'b1, 1'b0, exp_p}) begin
                    fails++;
                    $display("FAIL hold_stable: got ov=%b ir=%b P=%h expected ov=1 ir=0 P=%h",
                             out_valid, in_ready, P, exp_p);
                end
            end
            vec++;
            if (mul_cnt != pulses) begin
                fails++;
                $display("FAIL hold_no_mul: got %0d pulses expected 0", mul_cnt - pulses);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        vec++;
        if ({in_ready, busy, out_valid, P} !== {1'b1, 1'b0, 1'b0, exp_p}) begin
            fails++;
            $display("FAIL return_idle: got ir=%b busy=%b ov=%b P=%h expected ir=1 busy=0 ov=0 P=%h",
                     in_ready, busy, out_valid, P, exp_p);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; approx_en = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vec++;
        if ({in_ready, out_valid, busy, mul_en, P} !== {1'b1, 1'b0, 1'b0, 1'b0, 64'd0}) begin
            fails++;
            $display("FAIL reset_state: got ir=%b ov=%b busy=%b en=%b P=%h expected 1 0 0 0 0",
                     in_ready, out_valid, busy, mul_en, P);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_small();
        mul_log.delete();
        do_op(32'h00010002, 32'h00030004, 1'b0, 0);
        vec++;
        if (P !== 64'h00000003000A0008) begin
            fails++;
            $display("FAIL small_const: got %h expected 00000003000a0008", P);
        end
        vec++;
        if (mul_log.size() != 3) begin
            fails++;
            $display("FAIL small_mul_count: got %0d expected 3", mul_log.size());
        end else begin
            vec++;
            if ({mul_log[0], mul_log[1], mul_log[2]} !==
                {1'b0, 18'd1, 18'd3, 1'b0, 18'd2, 18'd4, 1'b0, 18'd3, 18'd7}) begin
                fails++;
                $display("FAIL small_mul_seq: got %h %h %h expected 1*3 2*4 3*7",
                         mul_log[0], mul_log[1], mul_log[2]);
            end
        end
    endtask

    task automatic test_max();
        mul_log.delete();
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
        vec++;
        if (P !== 64'hFFFFFFFE00000001) begin
            fails++;
            $display("FAIL max_const: got %h expected fffffffe00000001", P);
        end
        vec++;
        if (mul_log.size() != 3 || mul_log[2] !== {1'b0, 18'h1FFFE, 18'h1FFFE}) begin
            fails++;
            $display("FAIL max_mid_operands: got %0d entries last=%h expected 0 1fffe 1fffe",
                     mul_log.size(), (mul_log.size() == 3) ? mul_log[2] : 37'd0);
        end
    endtask

    task automatic test_edges();
        do_op(32'h0, 32'h12345678, 1'b0, 0);
        vec++;
        if (P !== 64'd0) begin
            fails++;
            $display("FAIL zero_const: got %h expected 0", P);
        end
        do_op(32'h12345678, 32'h1, 1'b0, 0);
        vec++;
        if (P !== 64'h12345678) begin
            fails++;
            $display("FAIL one_const: got %h expected 12345678", P);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            do_op($urandom, $urandom, 1'b0, 0);
        end
    endtask

    task automatic test_backpressure();
        do_op(32'hDEADBEEF, 32'h0BADF00D, 1'b0, 10);
        do_op(32'h00000009, 32'h0000000B, 1'b0, 0);
    endtask

    task automatic test_async_reset();
        A = 32'h00050006; B = 32'h00070008; approx_en = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vec++;
        if ({mul_en, mul_x, mul_y} !== {1'b1, 18'd11, 18'd15}) begin
            fails++;
            $display("FAIL mid_operands: got en=%b x=%h y=%h expected 1 b f", mul_en, mul_x, mul_y);
        end
        #2 rst = 1'b1;
        #1;
        vec++;
        if ({in_ready, busy, mul_en, out_valid, P} !== {1'b1, 1'b0, 1'b0, 1'b0, 64'd0}) begin
            fails++;
            $display("FAIL async_reset: got ir=%b busy=%b en=%b ov=%b P=%h expected 1 0 0 0 0",
                     in_ready, busy, mul_en, out_valid, P);
        end
        #1 rst = 1'b0;
        @(posedge clk); #1;
        do_op(32'd5, 32'd7, 1'b0, 0);
        vec++;
        if (P !== 64'd35) begin
            fails++;
            $display("FAIL after_reset_const: got %h expected 23", P);
        end
    endtask

    task automatic test_approx();
        mul_log.delete();
        do_op(32'h00010002, 32'h00030004, 1'b1, 0);
        vec++;
        if (P !== 64'h000000030007000B) begin
            fails++;
            $display("FAIL approx_const: got %h expected 000000030007000b", P);
        end
        vec++;
        if (mul_log.size() != 3 ||
            {mul_log[0][36], mul_log[1][36], mul_log[2][36]} !== 3'b010) begin
            fails++;
            $display("FAIL approx_flag_seq: got %0d entries expected flags 010 in 3 entries",
                     mul_log.size());
        end
        for (int i = 0; i < 5; i++) begin
            do_op($urandom, $urandom, 1'b1, 0);
        end
    endtask

    task automatic test_idle_mul_zero();
        vec++;
        if (idle_viol != 0) begin
            fails++;
            $display("FAIL idle_mul_zero: got %0d nonzero cycles expected 0", idle_viol);
        end
    endtask

    initial begin
        test_reset();
        test_small();
        test_max();
        test_edges();
        test_random();
        test_backpressure();
        test_async_reset();
        test_approx();
        test_idle_mul_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
        $finish;
    end

endmodule
